// File: rtl/voice_allocator_if.sv
// Report handshake between the HID/octave front end and the voice allocator.
interface voice_allocator_if #(
    parameter int NUM_KEYS = 6
);
    logic                       report_valid;
    logic                       report_ready;
    logic [NUM_KEYS-1:0][7:0]   keycodes;
    logic signed [31:0]         noteBase;

    modport master (output report_valid, keycodes, noteBase, input report_ready);
    modport slave  (input report_valid, keycodes, noteBase, output report_ready);
endinterface

// File: rtl/voice_allocator.sv
// Serial per-report voice allocator: release absent keys, then allocate new
// note keys to free voices, stealing the oldest voice when the pool is full.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_KEYS   = 6
) (
    input  logic                         Clk,
    input  logic                         Reset,
    voice_allocator_if.slave             rpt,
    output logic                         busy,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0][7:0]   voice_note,
    output logic [NUM_VOICES-1:0]        voice_trig
);
    localparam int CW = 4;
    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);
    localparam logic [CW-1:0] LAST_V  = CW'(NUM_VOICES - 1);
    localparam logic [CW-1:0] LAST_K  = CW'(NUM_KEYS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LATCH   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] ALLOC   = 2'd3;

    logic [1:0]                       state;
    logic [CW-1:0]                    cnt;
    logic [NUM_KEYS-1:0][7:0]         kc_lat;
    logic [NUM_VOICES-1:0][7:0]       vkey;
    logic [NUM_VOICES-1:0][AW-1:0]    age;

    logic [7:0]    slot_kc, rel_kc, new_note;
    logic [4:0]    km;
    logic          held, rel_hit, roll, found_free;
    logic [AW-1:0] tgt, best_age;
    logic [32:0]   sum;

    // {is_note, semitone offset}
    function automatic logic [4:0] key_map(input logic [7:0] kc);
        case (kc)
            8'h04:   key_map = {1'b1, 4'd0};
            8'h1A:   key_map = {1'b1, 4'd1};
            8'h16:   key_map = {1'b1, 4'd2};
            8'h08:   key_map = {1'b1, 4'd3};
            8'h07:   key_map = {1'b1, 4'd4};
            8'h09:   key_map = {1'b1, 4'd5};
            8'h17:   key_map = {1'b1, 4'd6};
            8'h0A:   key_map = {1'b1, 4'd7};
            8'h1C:   key_map = {1'b1, 4'd8};
            8'h0B:   key_map = {1'b1, 4'd9};
            8'h18:   key_map = {1'b1, 4'd10};
            8'h0D:   key_map = {1'b1, 4'd11};
            8'h0E:   key_map = {1'b1, 4'd12};
            default: key_map = 5'd0;
        endcase
    endfunction

    always_comb begin
        slot_kc = '0;
        rel_kc  = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (cnt == CW'(k)) slot_kc = kc_lat[k];
        for (int v = 0; v < NUM_VOICES; v++)
            if (cnt == CW'(v)) rel_kc = vkey[v];

        rel_hit = 1'b0;
        roll    = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (kc_lat[k] == rel_kc) rel_hit = 1'b1;
            if (kc_lat[k] == 8'h01)  roll    = 1'b1;
        end

        // Voices allocated earlier in this scan count as held, which drops duplicates.
        held = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (voice_active[v] && vkey[v] == slot_kc) held = 1'b1;

        found_free = 1'b0;
        tgt        = '0;
        best_age   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--)
            if (!voice_active[v]) begin
                found_free = 1'b1;
                tgt        = AW'(v);
            end
        // Strict compare keeps the lowest index among equally old voices.
        if (!found_free)
            for (int v = 0; v < NUM_VOICES; v++)
                if (age[v] > best_age) begin
                    best_age = age[v];
                    tgt      = AW'(v);
                end

        km  = key_map(slot_kc);
        sum = {rpt.noteBase[31], rpt.noteBase} + {29'd0, km[3:0]};
        if (sum[32])            new_note = 8'd0;
        else if (|sum[31:7])    new_note = 8'd127;
        else                    new_note = {1'b0, sum[6:0]};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            kc_lat       <= '0;
            vkey         <= '0;
            age          <= '0;
            voice_active <= '0;
            voice_note   <= '0;
            voice_trig   <= '0;
        end else begin
            voice_trig <= '0;
            case (state)
                IDLE: if (rpt.report_valid) begin
                    kc_lat <= rpt.keycodes;
                    state  <= LATCH;
                end
                LATCH: begin
                    cnt   <= '0;
                    state <= roll ? IDLE : RELEASE;
                end
                RELEASE: begin
                    for (int v = 0; v < NUM_VOICES; v++)
                        if (cnt == CW'(v) && voice_active[v] && !rel_hit)
                            voice_active[v] <= 1'b0;
                    if (cnt == LAST_V) begin
                        cnt   <= '0;
                        state <= ALLOC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (km[4] && !held)
                        for (int v = 0; v < NUM_VOICES; v++)
                            if (AW'(v) == tgt) begin
                                voice_active[v] <= 1'b1;
                                voice_note[v]   <= new_note;
                                vkey[v]         <= slot_kc;
                                voice_trig[v]   <= 1'b1;
                                age[v]          <= '0;
                            end else if (voice_active[v] && age[v] != AGE_MAX) begin
                                age[v] <= age[v] + 1'b1;
                            end
                    if (cnt == LAST_K) state <= IDLE;
                    else               cnt   <= cnt + 1'b1;
                end
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign rpt.report_ready = ~busy;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, stealing, release, rollover,
// clamping, dropped reports and asynchronous reset.
module tb_voice_allocator;
    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            busy;
    logic [3:0]      voice_active, voice_trig;
    logic [3:0][7:0] voice_note;

    voice_allocator_if #(.NUM_KEYS(6)) rif ();

    voice_allocator #(.NUM_VOICES(4), .NUM_KEYS(6)) dut (
        .Clk(Clk), .Reset(Reset), .rpt(rif), .busy(busy),
        .voice_active(voice_active), .voice_note(voice_note), .voice_trig(voice_trig)
    );

    always #5 Clk = ~Clk;

    int nerr = 0;
    int nchk = 0;
    logic [3:0] trig_or, act_and;
    int         trig_tot;

    always @(negedge Clk) begin
        trig_or  <= trig_or | voice_trig;
        act_and  <= act_and & voice_active;
        trig_tot <= trig_tot + $countones(voice_trig);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] kc(input logic [7:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic send(input logic [47:0] k, input int nb);
        @(negedge Clk);
        trig_or  = '0;
        act_and  = '1;
        trig_tot = 0;
        rif.report_valid = 1'b1;
        rif.keycodes     = k;
        rif.noteBase     = nb;
        @(posedge Clk);
        #1 rif.report_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!busy) break;
        end
        chk({tag, "_done"}, 32'(i < 40), 32'd1);
    endtask

    initial begin
        rif.report_valid = 1'b0;
        rif.keycodes     = '0;
        rif.noteBase     = 0;
        repeat (3) @(negedge Clk);
        chk("rst_active", 32'(voice_active), 32'h0);
        chk("rst_note",   voice_note,        32'h0);
        chk("rst_trig",   32'(voice_trig),   32'h0);
        chk("rst_busy",   32'(busy),         32'h0);
        chk("rst_ready",  32'(rif.report_ready), 32'h1);
        Reset = 1'b1;

        // single key
        send(kc(8'h04, 0, 0, 0, 0, 0), 6);
        chk("first_busy",  32'(busy), 32'h1);
        chk("first_ready", 32'(rif.report_ready), 32'h0);
        wait_done("first");
        chk("first_active", 32'(voice_active), 32'h1);
        chk("first_note",   voice_note, 32'h00000006);
        chk("first_trig",   32'(trig_or), 32'h1);
        chk("first_ntrig",  trig_tot, 32'd1);

        // fill the pool
        send(kc(8'h04, 8'h1A, 0, 0, 0, 0), 6);  wait_done("fill2");
        chk("fill2_trig", 32'(trig_or), 32'h2);
        chk("fill2_ntrig", trig_tot, 32'd1);
        send(kc(8'h04, 8'h1A, 8'h16, 0, 0, 0), 6); wait_done("fill3");
        send(kc(8'h04, 8'h1A, 8'h16, 8'h08, 0, 0), 6); wait_done("fill4");
        chk("fill_active", 32'(voice_active), 32'hF);
        chk("fill_note",   voice_note, 32'h09080706);

        // steal oldest (voice 0)
        send(kc(8'h04, 8'h1A, 8'h16, 8'h08, 8'h07, 0), 6); wait_done("steal");
        chk("steal_note",   voice_note, 32'h0908070A);
        chk("steal_active", 32'(voice_active), 32'hF);
        chk("steal_gate",   32'(act_and), 32'hF);
        chk("steal_trig",   32'(trig_or), 32'h1);
        chk("steal_ntrig",  trig_tot, 32'd1);

        // release all
        send(kc(0, 0, 0, 0, 0, 0), 6); wait_done("rel");
        chk("rel_active", 32'(voice_active), 32'h0);
        chk("rel_note",   voice_note, 32'h0908070A);
        chk("rel_ntrig",  trig_tot, 32'd0);

        // rollover report is discarded
        send(kc(8'h04, 8'h1A, 0, 0, 0, 0), 6); wait_done("hold2");
        chk("hold2_note", voice_note, 32'h09080706);
        send(kc(8'h01, 0, 0, 0, 0, 0), 6);
        chk("roll_busy1", 32'(busy), 32'h1);
        @(posedge Clk); #1;
        chk("roll_busy0", 32'(busy), 32'h0);
        chk("roll_active", 32'(voice_active), 32'h3);
        chk("roll_note",   voice_note, 32'h09080706);
        chk("roll_ntrig",  trig_tot, 32'd0);

        // clamp high, no retune, clamp low
        send(kc(8'h0E, 0, 0, 0, 0, 0), 120); wait_done("clamp");
        chk("clamp_note",   voice_note, 32'h0908077F);
        chk("clamp_active", 32'(voice_active), 32'h1);
        send(kc(8'h0E, 0, 0, 0, 0, 0), 6); wait_done("noretune");
        chk("noretune_note",  voice_note, 32'h0908077F);
        chk("noretune_ntrig", trig_tot, 32'd0);
        send(kc(8'h0E, 8'h04, 0, 0, 0, 0), -20); wait_done("neg");
        chk("neg_note", voice_note, 32'h0908007F);

        // report while busy is dropped, not queued
        send(kc(8'h0E, 8'h04, 8'h1A, 0, 0, 0), 6);
        repeat (2) @(negedge Clk);
        rif.report_valid = 1'b1;
        rif.keycodes     = kc(8'h16, 0, 0, 0, 0, 0);
        @(negedge Clk);
        rif.report_valid = 1'b0;
        wait_done("drop");
        chk("drop_active", 32'(voice_active), 32'h7);
        chk("drop_note",   voice_note, 32'h0907007F);
        repeat (3) @(negedge Clk);
        chk("drop_noqueue", 32'(busy), 32'h0);

        // async reset in ALLOC phase
        send(kc(8'h16, 8'h08, 0, 0, 0, 0), 6);
        repeat (6) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("arst_active", 32'(voice_active), 32'h0);
        chk("arst_note",   voice_note, 32'h0);
        chk("arst_trig",   32'(voice_trig), 32'h0);
        chk("arst_busy",   32'(busy), 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        send(kc(8'h07, 0, 0, 0, 0, 0), 6); wait_done("post");
        chk("post_active", 32'(voice_active), 32'h1);
        chk("post_note",   voice_note, 32'h0000000A);
        chk("post_ntrig",  trig_tot, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
